// File: rtl/kp_pkg.sv
// Shared types for the keypoint collector: the queued keypoint record and
// the field widths it is built from.
package kp_pkg;

  // Record fields are sized for the largest supported frame; ports trim them.
  localparam int KP_X_W     = 16;
  localparam int KP_Y_W     = 16;
  localparam int KP_SCORE_W = 8;

  typedef struct packed {
    logic [KP_X_W-1:0]     x;
    logic [KP_Y_W-1:0]     y;
    logic [KP_SCORE_W-1:0] score;
  } kp_t;

endpackage

// File: rtl/kp_fifo.sv
// Show-ahead keypoint FIFO: the head record is visible whenever not empty.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module kp_fifo
  import kp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  kp_t  push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output kp_t  head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  kp_t         mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/keypoint_collector.sv
// Turns a suppressed corner-score stream into queued (x, y, score) keypoint
// records, discarding the suppression pipeline fill at the start of a frame.
module keypoint_collector
  import kp_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int OFFSET = 644,
  parameter int DEPTH  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic                      i_sof,
  input  logic [7:0]                i_score,
  input  logic                      i_flag,
  output logic                      o_kp_valid,
  input  logic                      i_kp_ready,
  output logic [$clog2(WIDTH)-1:0]  o_kp_x,
  output logic [$clog2(HEIGHT)-1:0] o_kp_y,
  output logic [7:0]                o_kp_score,
  output logic [15:0]               o_kp_count,
  output logic                      o_overflow,
  output logic                      o_frame_done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int SW = $clog2(OFFSET + 2);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SKIP    = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]    state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [SW-1:0] skip_cnt;

  logic          start;
  logic          pixel_beat;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          last_x;
  logic          last_y;
  logic          last_beat;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          empty;
  logic          accept;
  logic          drop;
  logic [15:0]   count_base;
  logic          ovf_base;
  kp_t           push_data;
  kp_t           head;
  logic          unused_head_bits;

  // A start-of-frame beat restarts from pixel (0,0) regardless of state.
  assign start = i_valid && i_sof;
  assign px    = start ? '0 : x;
  assign py    = start ? '0 : y;

  // Beat number OFFSET (counting the sof beat as 0) is the first real pixel.
  always_comb begin
    pixel_beat = 1'b0;
    if (i_valid) begin
      if (start)
        pixel_beat = (OFFSET == 0);
      else
        pixel_beat = (state == S_COLLECT) ||
                     ((state == S_SKIP) && (skip_cnt == SW'(OFFSET)));
    end
  end

  assign last_x    = (px == XW'(WIDTH - 1));
  assign last_y    = (py == YW'(HEIGHT - 1));
  assign last_beat = pixel_beat && last_x && last_y;

  assign push_req = pixel_beat && i_flag;
  assign pop      = o_kp_valid && i_kp_ready;
  assign accept   = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign count_base = start ? 16'd0 : o_kp_count;
  assign ovf_base   = start ? 1'b0 : o_overflow;

  always_comb begin
    push_data       = '0;
    push_data.x     = KP_X_W'(px);
    push_data.y     = KP_Y_W'(py);
    push_data.score = i_score;
  end

  kp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (accept),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign o_kp_valid = !empty;
  assign o_kp_x     = head.x[XW-1:0];
  assign o_kp_y     = head.y[YW-1:0];
  assign o_kp_score = head.score;
  assign unused_head_bits = ^{head.x[KP_X_W-1:XW], head.y[KP_Y_W-1:YW]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      x            <= '0;
      y            <= '0;
      skip_cnt     <= '0;
      o_kp_count   <= '0;
      o_overflow   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= last_beat;
      o_overflow   <= ovf_base || drop;
      if (accept && (count_base != 16'hFFFF))
        o_kp_count <= count_base + 16'd1;
      else
        o_kp_count <= count_base;

      if (start) begin
        skip_cnt <= SW'(1);
        x        <= '0;
        y        <= '0;
        state    <= (OFFSET == 0) ? S_COLLECT : S_SKIP;
      end else if (i_valid && (state == S_SKIP) && !pixel_beat) begin
        skip_cnt <= skip_cnt + SW'(1);
      end

      // Pixel advance; overrides the start-of-frame values when OFFSET is 0.
      if (pixel_beat) begin
        state <= S_COLLECT;
        if (last_x) begin
          x <= '0;
          if (last_y) begin
            y     <= '0;
            state <= S_DONE;
          end else begin
            y <= py + YW'(1);
          end
        end else begin
          x <= px + XW'(1);
          y <= py;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypoint_collector.sv
// Directed bench for keypoint_collector at WIDTH=8, HEIGHT=4, OFFSET=2, DEPTH=4.
module tb_keypoint_collector;
  import kp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic       sof;
  logic [7:0] score;
  logic       flag;
  logic       kp_ready;
  logic       kp_valid;
  logic [2:0] kp_x;
  logic [1:0] kp_y;
  logic [7:0] kp_score;
  logic [15:0] kp_count;
  logic       overflow;
  logic       frame_done;

  int tests = 0;
  int fails = 0;
  int fd_seen;

  always #5 clk = ~clk;

  keypoint_collector #(
    .WIDTH  (8),
    .HEIGHT (4),
    .OFFSET (2),
    .DEPTH  (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_sof        (sof),
    .i_score      (score),
    .i_flag       (flag),
    .o_kp_valid   (kp_valid),
    .i_kp_ready   (kp_ready),
    .o_kp_x       (kp_x),
    .o_kp_y       (kp_y),
    .o_kp_score   (kp_score),
    .o_kp_count   (kp_count),
    .o_overflow   (overflow),
    .o_frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs applied after a falling edge, consumed at the next rising edge;
  // returns on the following falling edge so outputs can be sampled.
  task automatic step(input logic v, input logic s, input logic f,
                      input logic [7:0] sc, input logic rdy);
    valid    = v;
    sof      = s;
    flag     = f;
    score    = sc;
    kp_ready = rdy;
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [2:0] ex,
                          input logic [1:0] ey, input logic [7:0] es);
    chk({tag, "_valid"}, {31'd0, kp_valid}, 32'd1);
    chk({tag, "_x"}, {29'd0, kp_x}, {29'd0, ex});
    chk({tag, "_y"}, {30'd0, kp_y}, {30'd0, ey});
    chk({tag, "_score"}, {24'd0, kp_score}, {24'd0, es});
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; sof = 1'b0; flag = 1'b0; score = 8'd0; kp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, kp_valid}, 32'd0);
    chk("rst_count", {16'd0, kp_count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_x", {29'd0, kp_x}, 32'd0);
    rst_n = 1'b1;

    // Beats before any sof are ignored
    step(1, 0, 1, 8'hAA, 1);
    chk("pre_sof_valid", {31'd0, kp_valid}, 32'd0);

    // Single record at pixel 9 -> (1,1); fill-beat flags ignored
    step(1, 1, 1, 8'h11, 1);
    step(1, 0, 1, 8'h12, 1);
    chk("fill_valid", {31'd0, kp_valid}, 32'd0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 8'h00, 1);
    step(1, 0, 1, 8'h37, 1);
    chk_head("rec1", 3'd1, 2'd1, 8'h37);
    step(1, 0, 0, 8'h00, 1);
    chk("rec1_popped", {31'd0, kp_valid}, 32'd0);
    chk("rec1_count", {16'd0, kp_count}, 32'd1);

    // Remaining pixels 11..31, then flagged beats in DONE
    fd_seen = 0;
    for (int i = 11; i < 32; i++) begin
      step(1, 0, 0, 8'h00, 1);
      if (frame_done) fd_seen++;
    end
    chk("fd_on_last", {31'd0, frame_done}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 8'h77, 1);
      if (frame_done) fd_seen++;
    end
    chk("fd_once", fd_seen, 32'd1);
    chk("done_no_rec", {31'd0, kp_valid}, 32'd0);
    chk("done_count", {16'd0, kp_count}, 32'd1);

    // Overflow: 6 flagged beats with consumer stalled
    step(1, 1, 0, 8'h00, 0);
    step(1, 0, 1, 8'h00, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 8'h10 + 8'(i), 0);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {16'd0, kp_count}, 32'd4);
    chk_head("ovf_head", 3'd0, 2'd0, 8'h10);
    step(0, 0, 0, 8'h00, 0);
    chk_head("ovf_stable", 3'd0, 2'd0, 8'h10);
    for (int i = 0; i < 4; i++) begin
      chk_head("drain", 3'(i), 2'd0, 8'h10 + 8'(i));
      step(0, 0, 0, 8'h00, 1);
    end
    chk("drain_empty", {31'd0, kp_valid}, 32'd0);

    // Push into full FIFO with simultaneous pop
    step(1, 1, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 8'h20 + 8'(i), 0);
    chk("full_count", {16'd0, kp_count}, 32'd4);
    chk("full_ovf", {31'd0, overflow}, 32'd0);
    step(1, 0, 1, 8'h24, 1);
    chk("fullpop_count", {16'd0, kp_count}, 32'd5);
    chk("fullpop_ovf", {31'd0, overflow}, 32'd0);
    chk_head("fullpop_head", 3'd1, 2'd0, 8'h21);

    // Drop at y=2, then mid-frame sof clears status but keeps queue
    for (int i = 5; i < 16; i++) step(1, 0, 0, 8'h00, 0);
    step(1, 0, 1, 8'h99, 0);
    chk("drop_ovf", {31'd0, overflow}, 32'd1);
    chk("drop_count", {16'd0, kp_count}, 32'd5);
    step(1, 1, 0, 8'h00, 0);
    chk("resof_ovf", {31'd0, overflow}, 32'd0);
    chk("resof_count", {16'd0, kp_count}, 32'd0);
    chk_head("resof_head", 3'd1, 2'd0, 8'h21);
    step(1, 0, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 0);
    step(1, 0, 1, 8'h55, 1);
    chk("resof_push_count", {16'd0, kp_count}, 32'd1);
    chk_head("q1", 3'd2, 2'd0, 8'h22);
    step(0, 0, 0, 8'h00, 1);
    chk_head("q2", 3'd3, 2'd0, 8'h23);
    step(0, 0, 0, 8'h00, 1);
    chk_head("q3", 3'd4, 2'd0, 8'h24);
    step(0, 0, 0, 8'h00, 1);
    chk_head("q4", 3'd3, 2'd0, 8'h55);
    step(0, 0, 0, 8'h00, 1);
    chk("q_empty", {31'd0, kp_valid}, 32'd0);

    // Reset with three queued records
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'h60 + 8'(i), 0);
    chk("prerst_valid", {31'd0, kp_valid}, 32'd1);
    chk("prerst_count", {16'd0, kp_count}, 32'd4);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, kp_valid}, 32'd0);
    chk("arst_x", {29'd0, kp_x}, 32'd0);
    chk("arst_score", {24'd0, kp_score}, 32'd0);
    chk("arst_count", {16'd0, kp_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 0, 1, 8'h70, 1);
    chk("postrst_valid", {31'd0, kp_valid}, 32'd0);
    chk("postrst_count", {16'd0, kp_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
